// File: rtl/gray_step_decoder_if.sv
// -----------------------------------------------------------------------------
// gray_step_decoder_if
//   Bundles the signals between a Gray-sequence state counter consumer and
//   the gray_step_decoder.
//
//   Signals:
//     a_in, b_in : upstream 2-bit state {A,B}, synchronous to clk
//     clr        : synchronous clear of position/error state
//     pos        : two's-complement position count (POS_W bits, wraps)
//     dir        : direction of last legal step (1 = forward, 0 = reverse)
//     step       : one-cycle pulse per legal step
//     err        : one-cycle pulse per illegal transition
//     err_cnt    : saturating illegal-transition count (ERR_W bits)
//
//   Modports:
//     master : the side that drives the upstream state and clear
//     slave  : the decoder itself
// -----------------------------------------------------------------------------
interface gray_step_decoder_if #(
    parameter int POS_W = 8,
    parameter int ERR_W = 4
);
    logic             a_in;
    logic             b_in;
    logic             clr;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             step;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output a_in, b_in, clr,
        input  pos, dir, step, err, err_cnt
    );

    modport slave (
        input  a_in, b_in, clr,
        output pos, dir, step, err, err_cnt
    );
endinterface

// File: rtl/gray_step_decoder.sv
// -----------------------------------------------------------------------------
// gray_step_decoder
//   Samples a 2-bit Gray-sequence state {A,B} every clock and classifies the
//   change from the previous sample as a forward step, reverse step, hold or
//   illegal transition. Tracks a wrapping position count, the direction of
//   the last legal step and a saturating count of illegal transitions.
//
//   Ports:
//     clk : rising-edge clock, same domain as the upstream counter
//     rst : asynchronous reset, active-high
//     bus : gray_step_decoder_if.slave (a_in/b_in/clr in, status out)
//
//   Gray order (forward): 00 -> 01 -> 11 -> 10 -> 00.
//   All outputs are registered; one clock of latency from a sampled input
//   change to step/err/pos.
// -----------------------------------------------------------------------------
module gray_step_decoder #(
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    gray_step_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        TR_HOLD,
        TR_FWD,
        TR_REV,
        TR_ILL
    } trans_e;

    logic [1:0]       cur_ab;
    logic [1:0]       prev_ab_q;
    trans_e           trans;

    logic [POS_W-1:0] pos_q,     pos_d;
    logic             dir_q,     dir_d;
    logic             step_q,    step_d;
    logic             err_q,     err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    assign cur_ab = {bus.a_in, bus.b_in};

    // Forward successor of state {x,y} in the Gray order is {y,~x}; anything
    // that is neither a hold, the successor, nor the bitwise complement must
    // be the predecessor (a reverse step).
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        trans = TR_REV;
        if (cur_ab == prev_ab_q) begin
            trans = TR_HOLD;
        end else if (cur_ab == ~prev_ab_q) begin
            trans = TR_ILL;
        end else if (cur_ab == {prev_ab_q[0], ~prev_ab_q[1]}) begin
            trans = TR_FWD;
        end
    end

    always_comb begin
        pos_d     = pos_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (bus.clr) begin
            // A transition coinciding with clr is discarded.
            pos_d     = '0;
            dir_d     = 1'b1;
            err_cnt_d = '0;
        end else begin
            unique case (trans)
                TR_FWD: begin
                    pos_d  = pos_q + POS_W'(1);
                    dir_d  = 1'b1;
                    step_d = 1'b1;
                end
                TR_REV: begin
                    pos_d  = pos_q - POS_W'(1);
                    dir_d  = 1'b0;
                    step_d = 1'b1;
                end
                TR_ILL: begin
                    err_d = 1'b1;
                    if (err_cnt_q != {ERR_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
                default: ; // TR_HOLD: nothing changes
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            prev_ab_q <= 2'b00;
            pos_q     <= '0;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            // prev_ab tracks the input on clr cycles too, so the cleared
            // cycle's input is the new baseline rather than a transition.
            prev_ab_q <= cur_ab;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.pos     = pos_q;
    assign bus.dir     = dir_q;
    assign bus.step    = step_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_gray_step_decoder
//   Self-checking bench for gray_step_decoder: a table of directed vectors
//   {a, b, clr, expected outputs} applied one per clock, followed by
//   hand-written sequences for asynchronous reset, position wrap, error
//   counter saturation and decrement below zero.
// -----------------------------------------------------------------------------
module tb_gray_step_decoder;

    localparam int POS_W = 8;
    localparam int ERR_W = 4;

    logic clk;
    logic rst;

    gray_step_decoder_if #(.POS_W(POS_W), .ERR_W(ERR_W)) bus ();

    gray_step_decoder #(.POS_W(POS_W), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       clr;
        logic [7:0] pos;
        logic       dir;
        logic       step;
        logic       err;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] pos,
                             input logic dir, input logic step,
                             input logic err, input logic [3:0] cnt);
        check({tag, ".pos"},     16'($unsigned(bus.pos)), 16'(pos));
        check({tag, ".dir"},     16'(bus.dir),            16'(dir));
        check({tag, ".step"},    16'(bus.step),           16'(step));
        check({tag, ".err"},     16'(bus.err),            16'(err));
        check({tag, ".err_cnt"}, 16'(bus.err_cnt),        16'(cnt));
    endtask

    function automatic void add(input logic [1:0] ab, input logic clr,
                                input logic [7:0] pos, input logic dir,
                                input logic step, input logic err,
                                input logic [3:0] cnt);
        vec_t v;
        v.a    = ab[1];
        v.b    = ab[0];
        v.clr  = clr;
        v.pos  = pos;
        v.dir  = dir;
        v.step = step;
        v.err  = err;
        v.cnt  = cnt;
        vecs.push_back(v);
    endfunction

    // Drive inputs just after a rising edge; sample 1 time unit after the
    // next rising edge, when the registered outputs have settled.
    task automatic drive(input logic [1:0] ab, input logic clr);
        bus.a_in = ab[1];
        bus.b_in = ab[0];
        bus.clr  = clr;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] fwd_seq [4];

    initial begin
        fwd_seq[0] = 2'b01;
        fwd_seq[1] = 2'b11;
        fwd_seq[2] = 2'b10;
        fwd_seq[3] = 2'b00;

        //  ab     clr   pos    dir   step  err   cnt
        // forward Gray drive 00->01->11->10->00
        add(2'b01, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 4'd0);
        add(2'b11, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 4'd0);
        add(2'b10, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 4'd0);
        add(2'b00, 1'b0, 8'd4, 1'b1, 1'b1, 1'b0, 4'd0);
        // reverse 00->10->11, then hold 11 for three cycles
        add(2'b10, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 4'd0);
        add(2'b11, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, 4'd0);
        add(2'b11, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 4'd0);
        add(2'b11, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 4'd0);
        add(2'b11, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 4'd0);
        // reverse back to 00
        add(2'b01, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 4'd0);
        add(2'b00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        // B-variant sequence 00->11 (ill) ->10 (fwd) ->01 (ill) ->00 (rev)
        add(2'b11, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 4'd1);
        add(2'b10, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 4'd1);
        add(2'b01, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1, 4'd2);
        add(2'b00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd2);
        // clr coinciding with a 01->11 step
        add(2'b01, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 4'd2);
        add(2'b11, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        add(2'b11, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        add(2'b10, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 4'd0);
        // clr coinciding with an illegal 10->01 transition
        add(2'b01, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        add(2'b01, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Reset asserted before any clock edge, with a_in=b_in=1.
        bus.a_in = 1'b1;
        bus.b_in = 1'b1;
        bus.clr  = 1'b0;
        rst      = 1'b1;
        #2;
        check_all("rst0", 8'd0, 1'b1, 1'b0, 1'b0, 4'd0);

        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive({vecs[i].a, vecs[i].b}, vecs[i].clr);
            check_all($sformatf("v%0d", i), vecs[i].pos, vecs[i].dir,
                      vecs[i].step, vecs[i].err, vecs[i].cnt);
        end

        // Build nonzero state, then assert rst mid-cycle: outputs must clear
        // before the next clock edge.
        drive(2'b10, 1'b0);                  // 01->10 illegal, cnt=1
        drive(2'b11, 1'b0);                  // 10->11 reverse, pos=FF
        check_all("pre_rst", 8'hFF, 1'b0, 1'b1, 1'b0, 4'd1);
        #3;
        rst = 1'b1;
        #1;
        check_all("async_rst", 8'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // prev_ab restarts at 00: 00->01 must count as a forward step.
        drive(2'b01, 1'b0);
        check_all("post_rst", 8'd1, 1'b1, 1'b1, 1'b0, 4'd0);
        drive(2'b00, 1'b0);
        check_all("post_rst_back", 8'd0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Position wrap: 127 forward steps reach 7F, one more wraps to 80.
        for (int i = 0; i < 127; i++) drive(fwd_seq[i % 4], 1'b0);
        check_all("pos_7f", 8'h7F, 1'b1, 1'b1, 1'b0, 4'd0);
        drive(fwd_seq[127 % 4], 1'b0);
        check_all("pos_wrap", 8'h80, 1'b1, 1'b1, 1'b0, 4'd0);

        // Error counter saturation: 20 illegal toggles 00<->11.
        for (int i = 0; i < 20; i++) begin
            drive((i % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
            if (i == 14) check_all("cnt_15", 8'h80, 1'b1, 1'b0, 1'b1, 4'hF);
        end
        check_all("cnt_sat", 8'h80, 1'b1, 1'b0, 1'b1, 4'hF);
        drive(2'b00, 1'b0);
        check_all("cnt_hold", 8'h80, 1'b1, 1'b0, 1'b0, 4'hF);

        // Clear, then a reverse step from zero gives FF.
        drive(2'b00, 1'b1);
        check_all("clr", 8'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(2'b10, 1'b0);
        check_all("pos_neg1", 8'hFF, 1'b0, 1'b1, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
